// File: rtl/interrupt_sched_pkg.sv
// rtl/interrupt_sched_pkg.sv - shared state encoding and search helper for the interrupt scheduler.
package interrupt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    ASSERT = 2'd2
  } sched_state_e;

  localparam int MAX_SRC = 32;

  // Index of the first set bit of req[n-1:0] searching upward from start and wrapping; -1 if none.
  function automatic int first_set_from(input logic [MAX_SRC-1:0] req, input int start,
                                        input int n);
    int idx;
    first_set_from = -1;
    for (int k = MAX_SRC - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = start + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[4:0]]) first_set_from = idx;
      end
    end
  endfunction

endpackage

// File: rtl/interrupt_sched_rr_arbiter.sv
// rtl/interrupt_sched_rr_arbiter.sv - combinational grant selection; INTSCHED_FIXED_PRIO_EN selects fixed priority.
module rr_arbiter
  import interrupt_sched_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int VEC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [VEC_W-1:0] ptr,
  output logic [VEC_W-1:0] grant_idx,
  output logic             grant_vld
);

  int hit;

`ifdef INTSCHED_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb hit = first_set_from(MAX_SRC'(req), 0, N_SRC);
`else
  always_comb hit = first_set_from(MAX_SRC'(req), int'(ptr), N_SRC);
`endif

  assign grant_vld = (hit >= 0);
  assign grant_idx = VEC_W'(hit);

endmodule

// File: rtl/interrupt_sched_core.sv
// rtl/interrupt_sched_core.sv - edge capture, pending/overflow tracking and vectored IRQ FSM.
// INTSCHED_FIXED_PRIO_EN: fixed lowest-index priority, no round-robin pointer.
module interrupt_sched_core
  import interrupt_sched_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int VEC_W = $clog2(N_SRC)
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [N_SRC-1:0] irq_en,
  input  logic [N_SRC-1:0] clr_pend,
  input  logic             cpu_ack,
  output logic             irq_out,
  output logic [VEC_W-1:0] irq_vec,
  output logic [N_SRC-1:0] pend,
  output logic [N_SRC-1:0] ovf,
  output logic             busy
);

  sched_state_e     state;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] evt;
  logic [N_SRC-1:0] vec_mask;
  logic [N_SRC-1:0] clr_mask;
  logic [N_SRC-1:0] cand;
  logic [VEC_W-1:0] ptr_in;
  logic [VEC_W-1:0] grant_idx;
  logic             grant_vld;
  logic             ack_fire;
  logic             abort;

  assign evt      = irq_src & ~src_q;
  assign vec_mask = N_SRC'(1) << irq_vec;
  assign ack_fire = (state == ASSERT) && cpu_ack;
  assign abort    = (state == ASSERT) && !cpu_ack && (!irq_en[irq_vec] || clr_pend[irq_vec]);
  assign clr_mask = clr_pend | (ack_fire ? vec_mask : '0);
  assign cand     = pend & irq_en;
  assign busy     = (state != IDLE);

`ifdef INTSCHED_FIXED_PRIO_EN
  assign ptr_in = '0;
`else
  logic [VEC_W-1:0] rr_ptr;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rr_ptr <= '0;
    end else if (ack_fire) begin
      rr_ptr <= (int'(irq_vec) == N_SRC - 1) ? '0 : irq_vec + 1'b1;
    end
  end

  assign ptr_in = rr_ptr;
`endif

  rr_arbiter #(
    .N_SRC(N_SRC),
    .VEC_W(VEC_W)
  ) u_arb (
    .req      (cand),
    .ptr      (ptr_in),
    .grant_idx(grant_idx),
    .grant_vld(grant_vld)
  );

  // A new edge outranks any clear in the same cycle; overflow only counts against a bit that survives.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      src_q <= '0;
      pend  <= '0;
      ovf   <= '0;
    end else begin
      src_q <= irq_src;
      pend  <= (pend & ~clr_mask) | evt;
      ovf   <= (ovf & ~clr_pend) | (evt & pend & ~clr_mask);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= IDLE;
      irq_out <= 1'b0;
      irq_vec <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|cand) state <= ARB;
        end
        ARB: begin
          if (grant_vld) begin
            irq_vec <= grant_idx;
            irq_out <= 1'b1;
            state   <= ASSERT;
          end else begin
            state <= IDLE;
          end
        end
        ASSERT: begin
          if (ack_fire || abort) begin
            irq_out <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          irq_out <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
